alu_v3: RTL

Parametrised, pipelined signed fixed-point ALU that succeeds the v2 datapath. It computes load, add-immediate, dual-product multiply-add and multiply-accumulate operations at a configurable width and fraction position. A valid/ready handshake with backpressure wraps the datapath, and a sticky overflow flag reports out-of-range results. It sits between the decode/register-file read stage and writeback of the CPU core.

---
 rtl/alu_v3_pkg.sv | 27 ++
 rtl/alu_v3_mult_stage.sv | 51 +++++
 rtl/alu_v3.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_v3_pkg.sv
// alu_v3 shared types: opcodes, stage control payload, signed range helpers.
// Imported by the S2 multiply stage and the alu_v3 top level.
package alu_v3_pkg;

  typedef enum logic [2:0] {
    OP_LDSW = 3'd0,
    OP_LDA  = 3'd1,
    OP_ADDI = 3'd2,
    OP_MAC2 = 3'd3,
    OP_ACC  = 3'd4,
    OP_CLR  = 3'd5
  } alu_op_t;

  typedef struct packed {
    logic    vld;
    alu_op_t op;
  } ctl_t;

  function automatic longint smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/alu_v3_mult_stage.sv
// alu_v3 S2 register stage: both scaled products plus the payload
// that S3 still needs, all advancing on en.
module alu_v3_mult_stage
  import alu_v3_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  ctl_t                   ctl,
  input  logic [BUS_WIDTH-1:0]   sw,
  input  logic [BUS_WIDTH-1:0]   imm,
  input  logic [BUS_WIDTH-1:0]   a,
  input  logic [BUS_WIDTH-1:0]   b,
  input  logic [BUS_WIDTH-1:0]   c,
  output ctl_t                   ctl_q,
  output logic [BUS_WIDTH-1:0]   sw_q,
  output logic [BUS_WIDTH-1:0]   imm_q,
  output logic [BUS_WIDTH-1:0]   a_q,
  output logic [BUS_WIDTH+1:0]   p_ab,
  output logic [BUS_WIDTH+1:0]   p_ci
);

  localparam int SW = BUS_WIDTH + 2;
  localparam int PW = 2 * BUS_WIDTH;

  logic signed [PW-1:0] m_ab;
  logic signed [PW-1:0] m_ci;

  assign m_ab = $signed(a) * $signed(b);
  assign m_ci = $signed(c) * $signed(imm);

  always_ff @(posedge clk) begin
    if (!rst_n) ctl_q <= '0;
    else if (en) ctl_q <= ctl;
  end

  // Products are cut to the S3 sum width after the fraction shift
  always_ff @(posedge clk) begin
    if (en) begin
      sw_q  <= sw;
      imm_q <= imm;
      a_q   <= a;
      p_ab  <= SW'(m_ab >>> FRAC_BITS);
      p_ci  <= SW'(m_ci >>> FRAC_BITS);
    end
  end

endmodule

// File: rtl/alu_v3.sv
// alu_v3: 3-stage signed fixed-point ALU with valid/ready and sticky ovf.
// Define ALU_V3_SATURATE_EN to clamp out-of-range results instead of wrapping.
module alu_v3
  import alu_v3_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [BUS_WIDTH-1:0] sw,
  input  logic [BUS_WIDTH-1:0] imm,
  input  logic [BUS_WIDTH-1:0] data_a,
  input  logic [BUS_WIDTH-1:0] data_b,
  input  logic [BUS_WIDTH-1:0] data_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 ovf,
  output logic                 ovf_sticky
);

  localparam int SW = BUS_WIDTH + 2;
  localparam logic signed [SW-1:0] MAX = SW'(smax(BUS_WIDTH));
  localparam logic signed [SW-1:0] MIN = SW'(smin(BUS_WIDTH));

  function automatic logic signed [SW-1:0] ext(
    input logic [BUS_WIDTH-1:0] v
  );
    return {{2{v[BUS_WIDTH-1]}}, v};
  endfunction

  logic                  adv;
  ctl_t                  s1_ctl;
  ctl_t                  s2_ctl;
  logic [BUS_WIDTH-1:0]  s1_sw, s1_imm, s1_a, s1_b, s1_c;
  logic [BUS_WIDTH-1:0]  s2_sw, s2_imm, s2_a;
  logic [SW-1:0]         p_ab, p_ci;
  logic signed [SW-1:0]  sum;
  logic [BUS_WIDTH-1:0]  res_n;
  logic                  ovf_n;
  logic [BUS_WIDTH-1:0]  acc;

  assign in_ready = rst_n & (~out_valid | out_ready);
  assign adv      = in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) s1_ctl <= '0;
    else if (adv) s1_ctl <= '{vld: in_valid, op: alu_op_t'(op)};
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_sw  <= sw;
      s1_imm <= imm;
      s1_a   <= data_a;
      s1_b   <= data_b;
      s1_c   <= data_c;
    end
  end

  alu_v3_mult_stage #(
    .BUS_WIDTH(BUS_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_mult (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (adv),
    .ctl  (s1_ctl),
    .sw   (s1_sw),
    .imm  (s1_imm),
    .a    (s1_a),
    .b    (s1_b),
    .c    (s1_c),
    .ctl_q(s2_ctl),
    .sw_q (s2_sw),
    .imm_q(s2_imm),
    .a_q  (s2_a),
    .p_ab (p_ab),
    .p_ci (p_ci)
  );

  always_comb begin
    sum = '0;
    unique case (s2_ctl.op)
      OP_LDSW: sum = ext(s2_sw);
      OP_ADDI: sum = ext(s2_a) + ext(s2_imm);
      OP_MAC2: sum = $signed(p_ab) + $signed(p_ci);
      OP_ACC:  sum = ext(acc) + $signed(p_ab);
      OP_CLR:  sum = '0;
      default: sum = ext(s2_a);
    endcase
    ovf_n = (sum > MAX) || (sum < MIN);
`ifdef ALU_V3_SATURATE_EN
    if (sum > MAX)      res_n = MAX[BUS_WIDTH-1:0];
    else if (sum < MIN) res_n = MIN[BUS_WIDTH-1:0];
    else                res_n = sum[BUS_WIDTH-1:0];
`else
    res_n = sum[BUS_WIDTH-1:0];
`endif
  end

  // acc and flags move with the result entering the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else if (adv) begin
      out_valid <= s2_ctl.vld;
      if (s2_ctl.vld) begin
        result <= res_n;
        ovf    <= ovf_n;
        if (s2_ctl.op == OP_CLR) begin
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          if (s2_ctl.op == OP_ACC) acc <= res_n;
          if (ovf_n) ovf_sticky <= 1'b1;
        end
      end
    end
  end

endmodule
